multicycle_controller: RTL

- Multi-cycle sequencer for the existing 16-bit datapath: register bank, ALU, condition register, data memory and PC adder.
- Replaces the purely combinational single-cycle decode with an FSM that fetches over a req/ack handshake, decodes once, and steps through EXEC, MEM, WB and PCUPD.
- Issues one-cycle write/latch strobes and holds the mux/ALU selects stable for the whole instruction.
- Adds halt, bus-timeout error and a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 16-bit datapath: fetch over req/ack, decode once,
// then step EXEC/MEM/WB/PCUPD with one-cycle strobes, bus timeout and halt.
//
// state  | meaning
// FETCH  | imem_req high, waiting for imem_ack (ir_load on ack)
// DECODE | latch decode fields and selects from IR
// EXEC   | ALU settles, iscond for the ALU class
// MEM    | dmem_req high, waiting for dmem_ack
// WB     | isload strobe
// PCUPD  | pc_load strobe, instruction retires
// HALT   | sticky stop, left only by reset

module multicycle_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       IR,
    input  logic             d,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             ir_load,
    output logic [2:0]       fsel,
    output logic [2:0]       muxsel,
    output logic             isload,
    output logic             iscond,
    output logic             memrw,
    output logic             pc_load,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCUPD,
        S_HALT
    } state_t;

    state_t            state;
    logic [1:0]        cls;
    logic [1:0]        mode;
    logic              is_store;
    logic              do_wb;
    logic [1:0]        mux_lo;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              pc_src;

    logic [4:0]        op5;
    logic [2:0]        dec_fsel;
    logic              dec_store;
    logic              dec_wb;
    logic              dec_halt;

    always_comb begin
        op5       = IR[6:2];
        dec_store = (op5 == 5'b00001);
        dec_halt  = (IR == 7'b1111111);
        dec_wb    = !IR[6] && (op5 != 5'b00001) && (op5 != 5'b01010);
        if (op5 == 5'b01000 || IR[1:0] == 2'b10)
            dec_fsel = 3'b010;
        else if (IR == 7'd1)
            dec_fsel = 3'b000;
        else if (IR == 7'd0)
            dec_fsel = 3'b011;
        else if (op5 == 5'b01101)
            dec_fsel = 3'b100;
        else if (op5 == 5'b01100)
            dec_fsel = 3'b101;
        else if (op5 == 5'b01011)
            dec_fsel = 3'b110;
        else if (op5 == 5'b01001 || op5 == 5'b01010)
            dec_fsel = 3'b001;
        else
            dec_fsel = 3'b111;
    end

    // counts consecutive unacknowledged wait cycles; the TIMEOUT-th one trips
    assign wait_done = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_FETCH;
            cls         <= 2'b00;
            mode        <= 2'b00;
            is_store    <= 1'b0;
            do_wb       <= 1'b0;
            fsel        <= 3'b000;
            mux_lo      <= 2'b00;
            wait_cnt    <= '0;
            halted      <= 1'b0;
            bus_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        wait_cnt <= '0;
                        state    <= S_DECODE;
                    end else if (wait_done) begin
                        wait_cnt <= '0;
                        bus_err  <= 1'b1;
                        halted   <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    cls      <= IR[6:5];
                    mode     <= IR[1:0];
                    is_store <= dec_store;
                    do_wb    <= dec_wb;
                    fsel     <= dec_fsel;
                    mux_lo   <= {IR[0], (IR[1:0] != 2'b10)};
                    if (dec_halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_store || mode == 2'b10)
                        state <= S_MEM;
                    else if (do_wb)
                        state <= S_WB;
                    else
                        state <= S_PCUPD;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wait_cnt <= '0;
                        state    <= (mode == 2'b10) ? S_WB : S_PCUPD;
                    end else if (wait_done) begin
                        wait_cnt <= '0;
                        bus_err  <= 1'b1;
                        halted   <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    state <= S_PCUPD;
                end
                S_PCUPD: begin
                    instr_count <= instr_count + CNT_W'(1);
                    state       <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // the FETCH-state outputs are gated by rst so nothing escapes while held in reset
    assign imem_req = rst && (state == S_FETCH);
    assign ir_load  = rst && (state == S_FETCH) && imem_ack;
    assign dmem_req = (state == S_MEM);
    assign memrw    = (state == S_MEM) && is_store;
    assign iscond   = (state == S_EXEC) && (cls == 2'b01);
    assign isload   = (state == S_WB);
    assign pc_load  = (state == S_PCUPD);
    assign pc_src   = (state == S_PCUPD) && !((cls == 2'b11) || (cls == 2'b10 && d));
    assign muxsel   = {pc_src, mux_lo};

endmodule
